// File: rtl/mat_pkg.sv
// Shared sizes and FSM encoding for the weight-SRAM row reader.
package mat_pkg;

  localparam int DATA_W = 512;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;
  localparam int CNT_W  = 7;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

endpackage

// File: rtl/sram_row_reader_if.sv
// SRAM read port plus the valid/ready row stream leaving the reader.
interface sram_row_reader_if;
  import mat_pkg::*;

  logic              sram_csb;
  logic              sram_wsb;
  logic [ADDR_W-1:0] sram_raddr;
  logic [DATA_W-1:0] sram_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output sram_csb, sram_wsb, sram_raddr, out_valid, out_data, out_last,
    input  sram_rdata, out_ready
  );

  modport slave (
    input  sram_csb, sram_wsb, sram_raddr, out_valid, out_data, out_last,
    output sram_rdata, out_ready
  );

endinterface

// File: rtl/skid_fifo2.sv
// Two-entry registered FIFO carrying {last, data}; the head drives the output stream directly.
module skid_fifo2
  import mat_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         push_last,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         head_valid,
  output logic         head_last,
  output logic [W-1:0] head_data,
  output logic [1:0]   count
);

  logic [W-1:0] data0, data1;
  logic         last0, last1;
  logic [1:0]   count_q;
  logic         pop_ok;

  assign pop_ok = pop & (count_q != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      data0   <= '0;
      data1   <= '0;
      last0   <= 1'b0;
      last1   <= 1'b0;
      count_q <= 2'd0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (count_q == 2'd0) begin
            data0 <= push_data;
            last0 <= push_last;
          end else begin
            data1 <= push_data;
            last1 <= push_last;
          end
          if (count_q != 2'd2) count_q <= count_q + 2'd1;
        end
        2'b01: begin
          data0   <= data1;
          last0   <= last1;
          count_q <= count_q - 2'd1;
        end
        // Push and pop together: occupancy holds, the new row slots in behind any survivor.
        2'b11: begin
          if (count_q == 2'd1) begin
            data0 <= push_data;
            last0 <= push_last;
          end else begin
            data0 <= data1;
            last0 <= last1;
            data1 <= push_data;
            last1 <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_valid = (count_q != 2'd0);
  assign head_last  = last0 & head_valid;
  assign head_data  = data0;
  assign count      = count_q;

endmodule

// File: rtl/sram_row_reader.sv
// Fetches row_count consecutive SRAM rows from base_addr and streams them out over valid/ready.
module sram_row_reader
  import mat_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  row_count,
  output logic              busy,
  output logic              done,
  sram_row_reader_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  left_q, left_d;
  logic              inflight_q, inflight_last_q;
  logic              done_q, done_d;
  logic              issue, issue_last;
  logic              pop, credit_ok;
  logic [1:0]        fifo_count;

  assign pop = bus.out_valid & bus.out_ready;

  // A read may only go out if the row it returns is guaranteed a FIFO slot.
  assign credit_ok = ({1'b0, fifo_count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    left_d     = left_q;
    done_d     = 1'b0;
    issue      = 1'b0;
    issue_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (row_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ISSUE;
            addr_d  = base_addr;
            left_d  = row_count;
          end
        end
      end
      ISSUE: begin
        if (credit_ok) begin
          issue  = 1'b1;
          addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
          left_d = left_q - 1'b1;
          if (left_q == CNT_W'(1)) begin
            issue_last = 1'b1;
            state_d    = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && bus.out_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      left_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      left_q          <= left_d;
      inflight_q      <= issue;
      inflight_last_q <= issue_last;
      done_q          <= done_d;
    end
  end

  // The SRAM returns data one cycle after the issue, so the in-flight flag doubles as the push strobe.
  skid_fifo2 #(.W(DATA_W)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (inflight_q),
    .push_last  (inflight_last_q),
    .push_data  (bus.sram_rdata),
    .pop        (pop),
    .head_valid (bus.out_valid),
    .head_last  (bus.out_last),
    .head_data  (bus.out_data),
    .count      (fifo_count)
  );

  assign bus.sram_csb   = ~issue;
  assign bus.sram_wsb   = 1'b1;
  assign bus.sram_raddr = addr_q;
  assign busy           = (state_q != IDLE);
  assign done           = done_q;

endmodule

// File: tb/tb_sram_row_reader.sv
// Directed jobs plus random backpressure against a job-level model of the row reader.
module tb_sram_row_reader;
  import mat_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  row_count;
  logic              busy;
  logic              done;

  sram_row_reader_if bus ();

  sram_row_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .row_count (row_count),
    .busy      (busy),
    .done      (done),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] mem [DEPTH];

  // Behavioural SRAM with one-cycle registered read.
  always @(posedge clk) begin
    if (!bus.sram_csb) bus.sram_rdata <= mem[bus.sram_raddr];
  end

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs,
                             input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int        ready_mode = 0;
  bit  [5:0] ready_pat  = 6'b101001;
  int        pat_idx    = 0;

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1: begin
          bus.out_ready = ready_pat[pat_idx % 6];
          pat_idx++;
        end
        default: bus.out_ready = 1'(($urandom_range(0, 1)));
      endcase
    end
  end

  // Job-level reference model: expected rows, issue addresses and outstanding reads.
  logic [DATA_W-1:0] exp_q[$];
  bit                exp_last_q[$];
  int                issue_left    = 0;
  logic [ADDR_W-1:0] issue_addr    = '0;
  int                outstanding   = 0;
  bit                busy_exp      = 1'b0;
  bit                done_exp      = 1'b0;
  bit                stall_prev    = 1'b0;
  logic [DATA_W-1:0] stall_data    = '0;
  int                cycle         = 0;
  int                done_count    = 0;
  int                job_delivered = 0;
  int                job_first_hs  = 0;
  int                job_last_hs   = 0;

  always @(negedge clk) begin
    bit                busy_next, done_next, pop, row_last;
    logic [DATA_W-1:0] row;
    cycle++;
    if (rst) begin
      exp_q.delete();
      exp_last_q.delete();
      issue_left  = 0;
      outstanding = 0;
      busy_exp    = 1'b0;
      done_exp    = 1'b0;
      stall_prev  = 1'b0;
    end else begin
      checkOutput("busy", busy, busy_exp);
      checkOutput("done", done, done_exp);
      checkOutput("wsb", bus.sram_wsb, 1'b1);
      if (done) done_count++;
      busy_next = busy_exp;
      done_next = 1'b0;
      pop = bus.out_valid & bus.out_ready;

      if (stall_prev) begin
        checkOutput("stall_valid", bus.out_valid, 1'b1);
        checkOutput("stall_data", bus.out_data, stall_data);
      end

      if (!bus.sram_csb) begin
        checkOutput("csb_nothing_to_issue", issue_left > 0, 1'b1);
        checkOutput("csb_without_credit", (outstanding - int'(pop)) <= 1, 1'b1);
        if (issue_left > 0) begin
          checkOutput("raddr", bus.sram_raddr, issue_addr);
          issue_addr = issue_addr + 1'b1;
          issue_left--;
        end
      end

      if (pop) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_row", 1'b1, 1'b0);
        end else begin
          row      = exp_q.pop_front();
          row_last = exp_last_q.pop_front();
          checkOutput("row_data", bus.out_data, row);
          checkOutput("row_last", bus.out_last, row_last);
          if (job_delivered == 0) job_first_hs = cycle;
          job_last_hs = cycle;
          job_delivered++;
          if (row_last) begin
            done_next = 1'b1;
            busy_next = 1'b0;
          end
        end
      end

      outstanding = outstanding + int'(!bus.sram_csb) - int'(pop);
      checkOutput("outstanding_max3", outstanding <= 3, 1'b1);

      if (start && !busy) begin
        if (row_count == '0) begin
          done_next = 1'b1;
        end else begin
          busy_next     = 1'b1;
          issue_left    = int'(row_count);
          issue_addr    = base_addr;
          job_delivered = 0;
          for (int i = 0; i < int'(row_count); i++) begin
            exp_q.push_back(mem[(int'(base_addr) + i) % DEPTH]);
            exp_last_q.push_back(i == int'(row_count) - 1);
          end
        end
      end

      stall_prev = bus.out_valid & ~bus.out_ready;
      stall_data = bus.out_data;
      busy_exp   = busy_next;
      done_exp   = done_next;
    end
  end

  // Called at #1 after a rising edge; returns #1 after the edge that samples start.
  task automatic applyStimulus(input int base, input int count);
    start     = 1'b1;
    base_addr = ADDR_W'(base);
    row_count = CNT_W'(count);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int limit);
    int dc0;
    int n;
    dc0 = done_count;
    n   = 0;
    while (done_count == dc0 && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({"done_seen_", tag}, done_count > dc0, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_done"}, done, 1'b0);
    checkOutput({tag, "_csb"}, bus.sram_csb, 1'b1);
    checkOutput({tag, "_wsb"}, bus.sram_wsb, 1'b1);
    checkOutput({tag, "_raddr"}, bus.sram_raddr, '0);
    checkOutput({tag, "_valid"}, bus.out_valid, 1'b0);
    checkOutput({tag, "_last"}, bus.out_last, 1'b0);
    checkOutput({tag, "_data"}, bus.out_data, '0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int n;
    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    row_count = '0;
    for (int r = 0; r < DEPTH; r++)
      for (int w = 0; w < DATA_W / 32; w++)
        mem[r][w*32 +: 32] = $urandom;

    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] basic read base=0 count=4");
    applyStimulus(0, 4);
    checkOutput("first_issue_csb", bus.sram_csb, 1'b0);
    checkOutput("first_issue_raddr", bus.sram_raddr, '0);
    checkOutput("valid_cycle1", bus.out_valid, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("valid_edge1", bus.out_valid, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("valid_edge2", bus.out_valid, 1'b1);
    checkOutput("first_row", bus.out_data, mem[0]);
    waitDone("basic", 20);
    checkOutput("basic_consecutive", job_last_hs - job_first_hs, 3);

    $display("[TB] wrap-around base=62 count=4");
    applyStimulus(62, 4);
    waitDone("wrap", 20);

    $display("[TB] backpressure count=8 with ignored start");
    ready_mode = 1;
    @(posedge clk);
    #1;
    applyStimulus(5, 8);
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(40, 3);
    waitDone("backpressure", 60);
    ready_mode = 0;
    @(posedge clk);
    #1;

    $display("[TB] zero row_count");
    applyStimulus(7, 0);
    checkOutput("zero_done_pulse", done, 1'b1);
    checkOutput("zero_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("zero_done_low", done, 1'b0);

    $display("[TB] random jobs with random backpressure");
    ready_mode = 2;
    for (int j = 0; j < 6; j++) begin
      applyStimulus(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 20)));
      waitDone("random", 200);
    end
    ready_mode = 0;
    @(posedge clk);
    #1;

    $display("[TB] full sweep count=64");
    applyStimulus(0, 64);
    waitDone("sweep", 100);
    checkOutput("sweep_consecutive", job_last_hs - job_first_hs, 63);
    checkOutput("sweep_rows", job_delivered, 64);

    $display("[TB] reset mid-job");
    applyStimulus(20, 10);
    n = 0;
    while (job_delivered < 3 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("midjob_progress", job_delivered >= 3, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkResetValues("midjob_reset");
    applyStimulus(10, 2);
    waitDone("after_reset", 20);
    checkOutput("after_reset_rows", job_delivered, 2);
    checkOutput("no_leftover_rows", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
